// File: rtl/flash_chk_pkg.sv
// Shared constants for the flash read-back checker: FSM encoding, status bit
// positions and the flash page size.
package flash_chk_pkg;

  localparam int CHK_PAGE_BYTES = 256;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOP = 2'd1;
  localparam logic [1:0] ST_CHECK    = 2'd2;
  localparam logic [1:0] ST_REPORT   = 2'd3;

  localparam int CHK_ST_DATA  = 0;
  localparam int CHK_ST_FRAME = 1;
  localparam int CHK_ST_TMO   = 2;

endpackage

// File: rtl/flash_readback_checker_if.sv
// Check-request, read-stream and result signals of the flash read-back checker.
// master = requester/stream source, slave = checker.
interface flash_readback_checker_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic                    i_check_start;
  logic [8:0]              i_check_byte_num;
  logic [7:0]              i_check_seed;
  logic                    o_check_ready;
  logic [P_DATA_WIDTH-1:0] i_read_data;
  logic                    i_read_sop;
  logic                    i_read_eop;
  logic                    i_read_valid;
  logic                    o_done;
  logic                    o_pass;
  logic [2:0]              o_status;
  logic [8:0]              o_byte_cnt;
  logic [8:0]              o_err_cnt;
  logic [8:0]              o_first_err_idx;
  logic [7:0]              o_first_err_data;
  logic [7:0]              o_first_err_exp;

  modport master (
    output i_check_start, i_check_byte_num, i_check_seed,
    output i_read_data, i_read_sop, i_read_eop, i_read_valid,
    input  o_check_ready, o_done, o_pass, o_status, o_byte_cnt, o_err_cnt,
    input  o_first_err_idx, o_first_err_data, o_first_err_exp
  );

  modport slave (
    input  i_check_start, i_check_byte_num, i_check_seed,
    input  i_read_data, i_read_sop, i_read_eop, i_read_valid,
    output o_check_ready, o_done, o_pass, o_status, o_byte_cnt, o_err_cnt,
    output o_first_err_idx, o_first_err_data, o_first_err_exp
  );
endinterface

// File: rtl/flash_chk_pattern_gen.sv
// Incrementing byte pattern (byte k = seed + k, 8-bit wrap), shared with the
// write data generator so both sides of the flash path agree on the data.
module flash_chk_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] exp_byte
);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_byte <= 8'd0;
    end else if (load) begin
      exp_byte <= seed;
    end else if (advance) begin
      exp_byte <= exp_byte + 8'd1;
    end
  end

endmodule

// File: rtl/flash_readback_checker.sv
// Checks one flash read packet against the incrementing pattern and reports
// pass/fail, error count and first mismatch. Option: FLASH_CHK_TIMEOUT_EN.
module flash_readback_checker
  import flash_chk_pkg::*;
#(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_MAX_BYTES      = CHK_PAGE_BYTES,
  parameter int P_TIMEOUT_CYCLES = 65535
) (
  input logic                     i_clk,
  input logic                     i_rst,
  flash_readback_checker_if.slave bus
);

  localparam logic [9:0] MAX_BYTES = 10'(P_MAX_BYTES);

  logic [1:0] state;
  logic [8:0] byte_num;
  logic [8:0] byte_cnt;
  logic [8:0] err_cnt;
  logic [8:0] first_idx;
  logic [7:0] first_data;
  logic [7:0] first_exp;
  logic [2:0] status;
  logic       have_result;
  logic [7:0] exp_byte;
  logic       start_ok;
  logic       beat;
  logic       len_ok;
  logic       in_range;
  logic       cmp_en;
  logic       mismatch;
  logic       tmo_hit;

  assign start_ok = (state == ST_IDLE) && bus.i_check_start;
  assign beat     = bus.i_read_valid;
  assign len_ok   = (byte_num != 9'd0) && ({1'b0, byte_num} <= MAX_BYTES);
  assign in_range = byte_cnt < byte_num;
  assign mismatch = bus.i_read_data != exp_byte;
  assign cmp_en   = beat &&
                    (((state == ST_WAIT_SOP) && bus.i_read_sop && len_ok) ||
                     ((state == ST_CHECK) && in_range));

  flash_chk_pattern_gen u_pattern (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (start_ok),
    .seed     (bus.i_check_seed),
    .advance  (cmp_en),
    .exp_byte (exp_byte)
  );

`ifdef FLASH_CHK_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cycles;
  logic          waiting;

  assign waiting = (state == ST_WAIT_SOP) || (state == ST_CHECK);
  assign tmo_hit = waiting && !beat && (idle_cycles == TW'(P_TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !waiting || beat) begin
      idle_cycles <= '0;
    end else begin
      idle_cycles <= idle_cycles + TW'(1);
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (P_TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  // Zero or oversized lengths are rejected one cycle after start without
  // touching the stream, so any beat present then is left alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      byte_num    <= '0;
      byte_cnt    <= '0;
      err_cnt     <= '0;
      first_idx   <= '0;
      first_data  <= '0;
      first_exp   <= '0;
      status      <= '0;
      have_result <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_check_start) begin
            byte_num    <= bus.i_check_byte_num;
            byte_cnt    <= '0;
            err_cnt     <= '0;
            first_idx   <= '0;
            first_data  <= '0;
            first_exp   <= '0;
            status      <= '0;
            have_result <= 1'b0;
            state       <= ST_WAIT_SOP;
          end
        end
        ST_WAIT_SOP: begin
          if (!len_ok) begin
            status[CHK_ST_FRAME] <= 1'b1;
            state                <= ST_REPORT;
          end else if (tmo_hit) begin
            status[CHK_ST_TMO] <= 1'b1;
            state              <= ST_REPORT;
          end else if (beat) begin
            if (bus.i_read_sop) begin
              byte_cnt <= 9'd1;
              if (bus.i_read_eop) begin
                if (byte_num > 9'd1) status[CHK_ST_FRAME] <= 1'b1;
                state <= ST_REPORT;
              end else begin
                state <= ST_CHECK;
              end
            end else begin
              status[CHK_ST_FRAME] <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (tmo_hit) begin
            status[CHK_ST_TMO] <= 1'b1;
            state              <= ST_REPORT;
          end else if (beat) begin
            if (in_range) begin
              byte_cnt <= byte_cnt + 9'd1;
              if (bus.i_read_sop) status[CHK_ST_FRAME] <= 1'b1;
              if (bus.i_read_eop) begin
                if (9'(byte_cnt + 9'd1) < byte_num) status[CHK_ST_FRAME] <= 1'b1;
                state <= ST_REPORT;
              end
            end else begin
              status[CHK_ST_FRAME] <= 1'b1;
              if (bus.i_read_eop) state <= ST_REPORT;
            end
          end
        end
        default: begin
          have_result <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase

      if (cmp_en && mismatch) begin
        status[CHK_ST_DATA] <= 1'b1;
        if (err_cnt != 9'h1FF) err_cnt <= err_cnt + 9'd1;
        if (err_cnt == 9'd0) begin
          first_idx  <= byte_cnt;
          first_data <= bus.i_read_data;
          first_exp  <= exp_byte;
        end
      end
    end
  end

  assign bus.o_check_ready    = (state == ST_IDLE);
  assign bus.o_done           = (state == ST_REPORT);
  assign bus.o_pass           = (have_result || (state == ST_REPORT)) && (status == 3'b000);
  assign bus.o_status         = status;
  assign bus.o_byte_cnt       = byte_cnt;
  assign bus.o_err_cnt        = err_cnt;
  assign bus.o_first_err_idx  = first_idx;
  assign bus.o_first_err_data = first_data;
  assign bus.o_first_err_exp  = first_exp;

endmodule

// File: tb/tb_flash_readback_checker.sv
// Directed self-checking bench for flash_readback_checker; the timeout step
// runs only when FLASH_CHK_TIMEOUT_EN is defined.
module tb_flash_readback_checker;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  flash_readback_checker_if #(.P_DATA_WIDTH(8)) bus ();

  flash_readback_checker #(
    .P_DATA_WIDTH     (8),
    .P_MAX_BYTES      (256),
    .P_TIMEOUT_CYCLES (100)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One read beat; returns 1 time unit after the edge that sampled it.
  task automatic applyStimulus(input logic valid, input logic sop, input logic eop,
                               input logic [7:0] data);
    bus.i_read_valid = valid;
    bus.i_read_sop   = sop;
    bus.i_read_eop   = eop;
    bus.i_read_data  = data;
    @(posedge i_clk);
    #1;
    bus.i_read_valid = 1'b0;
    bus.i_read_sop   = 1'b0;
    bus.i_read_eop   = 1'b0;
  endtask

  task automatic startCheck(input logic [8:0] num, input logic [7:0] seed);
    bus.i_check_start    = 1'b1;
    bus.i_check_byte_num = num;
    bus.i_check_seed     = seed;
    @(posedge i_clk);
    #1;
    bus.i_check_start = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bus.i_check_start    = 1'b0;
    bus.i_check_byte_num = '0;
    bus.i_check_seed     = '0;
    bus.i_read_data      = '0;
    bus.i_read_sop       = 1'b0;
    bus.i_read_eop       = 1'b0;
    bus.i_read_valid     = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_ready", bus.o_check_ready, 1);
    checkOutput("reset_done", bus.o_done, 0);
    checkOutput("reset_pass", bus.o_pass, 0);
    checkOutput("reset_status", bus.o_status, 0);
    i_rst = 1'b0;
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] clean packet, with a stray beat in the start cycle");
    bus.i_read_valid = 1'b1;
    bus.i_read_sop   = 1'b1;
    bus.i_read_data  = 8'h55;
    startCheck(9'd32, 8'h10);
    bus.i_read_valid = 1'b0;
    bus.i_read_sop   = 1'b0;
    checkOutput("start_ready_low", bus.o_check_ready, 0);
    checkOutput("start_byte_cnt", bus.o_byte_cnt, 0);
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1, k == 0, k == 31, 8'(8'h10 + k));
      if (k == 3) checkOutput("clean_cnt_after_beat3", bus.o_byte_cnt, 4);
    end
    checkOutput("clean_done", bus.o_done, 1);
    checkOutput("clean_pass", bus.o_pass, 1);
    checkOutput("clean_status", bus.o_status, 0);
    checkOutput("clean_byte_cnt", bus.o_byte_cnt, 32);
    checkOutput("clean_err_cnt", bus.o_err_cnt, 0);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("clean_done_1cyc", bus.o_done, 0);
    checkOutput("clean_ready_back", bus.o_check_ready, 1);
    checkOutput("clean_pass_held", bus.o_pass, 1);

    $display("[TB] full page with two corrupt bytes and pattern wrap");
    startCheck(9'd256, 8'hF0);
    for (int k = 0; k < 256; k++) begin
      d = 8'(8'hF0 + k);
      if (k == 5)   d = 8'hAA;
      if (k == 200) d = 8'h00;
      applyStimulus(1, k == 0, k == 255, d);
      if (k == 20) checkOutput("wrap_err_cnt_k20", bus.o_err_cnt, 1);
    end
    checkOutput("corrupt_done", bus.o_done, 1);
    checkOutput("corrupt_pass", bus.o_pass, 0);
    checkOutput("corrupt_status", bus.o_status, 3'b001);
    checkOutput("corrupt_err_cnt", bus.o_err_cnt, 2);
    checkOutput("corrupt_byte_cnt", bus.o_byte_cnt, 256);
    checkOutput("corrupt_first_idx", bus.o_first_err_idx, 5);
    checkOutput("corrupt_first_data", bus.o_first_err_data, 8'hAA);
    checkOutput("corrupt_first_exp", bus.o_first_err_exp, 8'hF5);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] short packet");
    startCheck(9'd8, 8'h00);
    for (int k = 0; k < 5; k++) applyStimulus(1, k == 0, k == 4, 8'(k));
    checkOutput("short_done", bus.o_done, 1);
    checkOutput("short_status", bus.o_status, 3'b010);
    checkOutput("short_byte_cnt", bus.o_byte_cnt, 5);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] long packet");
    startCheck(9'd4, 8'h40);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, k == 0, k == 5, (k < 4) ? 8'(8'h40 + k) : 8'hEE);
      if (k == 3) checkOutput("long_no_done_yet", bus.o_done, 0);
      if (k == 3) checkOutput("long_status_exact", bus.o_status, 0);
    end
    checkOutput("long_done", bus.o_done, 1);
    checkOutput("long_status", bus.o_status, 3'b010);
    checkOutput("long_byte_cnt", bus.o_byte_cnt, 4);
    checkOutput("long_err_cnt", bus.o_err_cnt, 0);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] single byte with sop and eop together");
    startCheck(9'd1, 8'h7C);
    applyStimulus(1, 1, 1, 8'h7C);
    checkOutput("one_done", bus.o_done, 1);
    checkOutput("one_pass", bus.o_pass, 1);
    checkOutput("one_byte_cnt", bus.o_byte_cnt, 1);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] zero length");
    startCheck(9'd0, 8'h00);
    checkOutput("zero_not_done_yet", bus.o_done, 0);
    applyStimulus(1, 1, 0, 8'h00);
    checkOutput("zero_done", bus.o_done, 1);
    checkOutput("zero_status", bus.o_status, 3'b010);
    checkOutput("zero_byte_cnt", bus.o_byte_cnt, 0);
    checkOutput("zero_pass", bus.o_pass, 0);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] stray beat before sop and start while busy");
    startCheck(9'd4, 8'h20);
    applyStimulus(1, 0, 0, 8'h99);
    checkOutput("stray_byte_cnt", bus.o_byte_cnt, 0);
    checkOutput("stray_status", bus.o_status, 3'b010);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        bus.i_check_start    = 1'b1;
        bus.i_check_byte_num = 9'd9;
        bus.i_check_seed     = 8'h00;
      end
      applyStimulus(1, k == 0, k == 3, 8'(8'h20 + k));
      bus.i_check_start = 1'b0;
      if (k == 1) checkOutput("busy_ready_low", bus.o_check_ready, 0);
    end
    checkOutput("busy_done", bus.o_done, 1);
    checkOutput("busy_byte_cnt", bus.o_byte_cnt, 4);
    checkOutput("busy_err_cnt", bus.o_err_cnt, 0);
    checkOutput("busy_status", bus.o_status, 3'b010);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] reset mid-packet");
    startCheck(9'd32, 8'h00);
    for (int k = 0; k < 10; k++) applyStimulus(1, k == 0, 0, (k == 2) ? 8'hFF : 8'(k));
    checkOutput("pre_reset_err_cnt", bus.o_err_cnt, 1);
    checkOutput("pre_reset_byte_cnt", bus.o_byte_cnt, 10);
    i_rst = 1'b1;
    applyStimulus(1, 0, 0, 8'd10);
    checkOutput("rst_ready", bus.o_check_ready, 1);
    checkOutput("rst_byte_cnt", bus.o_byte_cnt, 0);
    checkOutput("rst_err_cnt", bus.o_err_cnt, 0);
    checkOutput("rst_status", bus.o_status, 0);
    checkOutput("rst_first_idx", bus.o_first_err_idx, 0);
    checkOutput("rst_first_exp", bus.o_first_err_exp, 0);
    checkOutput("rst_pass", bus.o_pass, 0);
    i_rst = 1'b0;
    applyStimulus(0, 0, 0, 8'h00);

`ifdef FLASH_CHK_TIMEOUT_EN
    begin
      int waited;
      $display("[TB] stalled stream watchdog");
      startCheck(9'd4, 8'h00);
      applyStimulus(1, 1, 0, 8'h00);
      waited = 0;
      while (!bus.o_done && waited < 200) begin
        applyStimulus(0, 0, 0, 8'h00);
        waited++;
      end
      checkOutput("tmo_done", bus.o_done, 1);
      checkOutput("tmo_cycles", waited, 100);
      checkOutput("tmo_status", bus.o_status, 3'b100);
      applyStimulus(0, 0, 0, 8'h00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_readback_checker.md
# flash_readback_checker

Downstream consumer of the flash driver's read stream. Takes a check request (expected length and pattern seed), consumes one read packet from `o_read_*` of `Flash_drive`, and compares each byte against an incrementing pattern. The pattern is byte k = seed + k mod 256, the same pattern the user data generator writes. Reports pass/fail, error count and the first mismatch, for on-board self-test and simulation sign-off of the SPI flash path.

## Interface
Parameters:
- `P_DATA_WIDTH`, 8: read data width. Only 8 is supported.
- `P_MAX_BYTES`, 256: maximum packet length; one flash page.
- `P_TIMEOUT_CYCLES`, 65535: watchdog limit. Used only with `FLASH_CHK_TIMEOUT_EN`.

Ports:
- `i_clk`, in, 1: the only clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_check_start`, in, 1: request strobe.
- `i_check_byte_num`, in, 9: expected byte count, valid range 1..256.
- `i_check_seed`, in, 8: pattern value of byte 0.
- `o_check_ready`, out, 1: high only in IDLE.
- `i_read_data`, in, `P_DATA_WIDTH`: read byte.
- `i_read_sop`, in, 1: first beat of a packet.
- `i_read_eop`, in, 1: last beat of a packet.
- `i_read_valid`, in, 1: beat qualifier.
- `o_done`, out, 1: one-cycle result pulse.
- `o_pass`, out, 1: high when `o_status` == 0. Valid from `o_done` until the next accepted start.
- `o_status`, out, 3: sticky flags. bit0 = data mismatch, bit1 = framing, bit2 = timeout.
- `o_byte_cnt`, out, 9: beats compared.
- `o_err_cnt`, out, 9: mismatching bytes; saturates at 511.
- `o_first_err_idx`, out, 9: index of the first mismatching byte.
- `o_first_err_data`, out, 8: received value at the first mismatch.
- `o_first_err_exp`, out, 8: expected value at the first mismatch.

## Operation
- **States:** IDLE, WAIT_SOP, CHECK, REPORT.
- **IDLE:**
  - `o_check_ready` = 1.
  - `i_check_start` is captured together with length and seed; clears counters, status and first-error fields; goes to WAIT_SOP.
  - Read beats arriving in IDLE are ignored, including a beat in the same cycle as start.
- **Zero length:** a start with byte_num = 0 sets framing, goes straight to REPORT, and consumes no beats.
- **WAIT_SOP:**
  - A beat with sop is compared as byte 0 and the FSM enters CHECK.
  - If that same beat also carries eop, go to REPORT instead.
  - A beat without sop is dropped and sets framing.
- **CHECK:**
  - Every valid beat while byte_cnt < byte_num is compared against seed + byte_cnt (8-bit wrap), then byte_cnt increments.
  - On a mismatch, err_cnt increments. The first mismatch latches idx, data and exp; later mismatches do not overwrite them.
  - sop seen again mid-packet sets framing; the beat is still compared as data.
  - eop with byte_cnt + 1 < byte_num (short packet) sets framing and goes to REPORT.
  - Beats beyond byte_num (long packet) set framing, are not compared and are not counted; the FSM waits for eop and then goes to REPORT.
- **REPORT:** `o_done` = 1 for one cycle, then IDLE.
- **Outputs:** all result outputs hold their values until the next accepted start.
- **Reset:** reset in any state, including mid-packet, returns to IDLE and clears every output.

## Timing
- **Reset values:** `o_check_ready` = 1. All other outputs, including `o_pass`, are 0.
- **Start:** a start accepted at edge N gives ready = 0 from cycle N+1.
- **Per-beat latency:** compare result is visible on counters one cycle after the beat.
- **Completion:** eop beat at cycle N → `o_done` = 1 at cycle N+1 → ready = 1 at N+2. This gives two cycles between back-to-back checks.
- **Throughput:** the read stream has no backpressure, so one beat per cycle must be accepted in CHECK.
- **Index width:** byte index is 9 bits and holds 0..255. byte_num = 256 is a legal value.

## Configuration
Macro `FLASH_CHK_TIMEOUT_EN`:
- **Defined:**
  - A watchdog counts cycles without `i_read_valid` in WAIT_SOP and CHECK, and resets on every valid beat.
  - Reaching `P_TIMEOUT_CYCLES` sets status bit2 and goes to REPORT.
- **Undefined:** no counter is built, bit2 is tied to 0, and the checker waits indefinitely.

## Structure
- **Package `flash_chk_pkg`:**
  - FSM state encoding.
  - Status bit index constants: `CHK_ST_DATA` = 0, `CHK_ST_FRAME` = 1, `CHK_ST_TMO` = 2.
  - Page size constant 256.
- **Sub-module `flash_chk_pattern_gen`:**
  - Loads seed on start and advances on each compared beat.
  - Outputs the expected byte.
  - Reusable by the write data generator so both sides share the pattern.

## Test plan
- **Clean packet:** seed 0x10, byte_num 32, 32 beats 0x10..0x2F, eop on beat 31 → `o_done` one cycle later, pass = 1, status = 0, byte_cnt = 32, err_cnt = 0.
- **Corruption and wrap:** seed 0xF0, byte_num 256, byte 5 = 0xAA and byte 200 = 0x00 → err_cnt = 2, first_err_idx = 5, data = 0xAA, exp = 0xF5, status = 001. Pattern wraps at byte 16 (0xFF→0x00) without error.
- **Framing:** byte_num 8 with eop on beat 4 → status = 010, byte_cnt = 5. Separately, byte_num 4 with 6 beats → status = 010, byte_cnt = 4, `o_done` after beat 6.
- **Edge cases:**
  - byte_num 1 with sop and eop on the same beat, correct data → pass.
  - byte_num 0 → done two cycles after start, status = 010.
- **Stray beat and busy start:** a beat without sop in WAIT_SOP → dropped, framing set. A start pulse during CHECK is ignored.
- **Reset and timeout:** reset asserted mid-packet at beat 10 → next cycle ready = 1 and all results 0. With `FLASH_CHK_TIMEOUT_EN` and `P_TIMEOUT_CYCLES` = 100, stalling the stream → status = 100, done asserted.
